// File: rtl/map_access_arbiter.sv
// map_access_arbiter: shares the single-port map RAM between the Pac-Man and ghost
// movers, checks the target cell for collisions, and keeps the pill counter.
module map_access_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter int         RD_LAT    = 1,
    parameter logic [9:0] PILL_INIT = 10'd300
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [6*NUM_REQ-1:0] curr_x,
    input  logic [5*NUM_REQ-1:0] curr_y,
    input  logic [6*NUM_REQ-1:0] next_x,
    input  logic [5*NUM_REQ-1:0] next_y,
    input  logic [3:0]           ram_rdata,
    output logic [10:0]          ram_addr,
    output logic                 ram_we,
    output logic [3:0]           ram_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [3:0]           collision_type,
    output logic                 collision_valid,
    output logic [9:0]           pill_count,
    output logic                 pills_clear
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE, RD, CHK, WR_OLD, WR_NEW, DONE
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] rr_ptr, g, win;
    logic [PW:0]   sum, nxt;
    logic          any;
    logic [5:0]    cx, nx;
    logic [4:0]    cy, ny;
    logic [1:0]    cnt;
    logic [3:0]    under [NUM_REQ];
    logic [3:0]    sprite;
    logic          blocked;

    assign sprite  = (g == '0) ? 4'd3 : 4'd3 + 4'(g);
    assign blocked = (ram_rdata == 4'd1) || (ram_rdata >= 4'd3);

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        win = '0;
        any = 1'b0;
        sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            if (!any && req[sum[PW-1:0]]) begin
                win = sum[PW-1:0];
                any = 1'b1;
            end
        end
        nxt = {1'b0, win} + 1'b1;
        if (nxt == (PW+1)'(NUM_REQ))
            nxt = '0;
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (any) state_n = RD;
            RD:      if (cnt == 2'd0) state_n = CHK;
            CHK:     state_n = blocked ? DONE : WR_OLD;
            WR_OLD:  state_n = WR_NEW;
            WR_NEW:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Transaction datapath: grant, latched coordinates, under-cells, pills.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr         <= '0;
            g              <= '0;
            grant          <= '0;
            cx             <= '0;
            cy             <= '0;
            nx             <= '0;
            ny             <= '0;
            cnt            <= '0;
            collision_type <= '0;
            pill_count     <= PILL_INIT;
            for (int i = 0; i < NUM_REQ; i++)
                under[i] <= '0;
        end else begin
            unique case (state)
                IDLE: if (any) begin
                    g      <= win;
                    grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    rr_ptr <= nxt[PW-1:0];
                    cx     <= curr_x[6*int'(win) +: 6];
                    cy     <= curr_y[5*int'(win) +: 5];
                    nx     <= next_x[6*int'(win) +: 6];
                    ny     <= next_y[5*int'(win) +: 5];
                    cnt    <= 2'(RD_LAT - 1);
                end
                RD: if (cnt != 2'd0) cnt <= cnt - 2'd1;
                CHK: collision_type <= ram_rdata;
                WR_NEW: begin
                    if (g == '0) begin
                        under[g] <= 4'd0;
                        if (collision_type == 4'd2 && pill_count != '0)
                            pill_count <= pill_count - 10'd1;
                    end else begin
                        under[g] <= collision_type;
                    end
                end
                DONE: grant <= '0;
                default: ;
            endcase
        end
    end

    // RAM port and handshake outputs decoded from registers only.
    always_comb begin
        ram_addr        = '0;
        ram_we          = 1'b0;
        ram_wdata       = '0;
        done            = '0;
        collision_valid = 1'b0;
        unique case (state)
            RD, CHK: ram_addr = {ny, nx};
            WR_OLD: begin
                ram_addr  = {cy, cx};
                ram_wdata = under[g];
                ram_we    = 1'b1;
            end
            WR_NEW: begin
                ram_addr  = {ny, nx};
                ram_wdata = sprite;
                ram_we    = 1'b1;
            end
            DONE: begin
                done            = grant;
                collision_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign pills_clear = (pill_count == '0);

endmodule
